// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IF/DM requester ports and memory-side bus of mem_port_arbiter
interface mem_port_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W/8-1:0] dm_be;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port memory shared by IF and DM, DM priority, one transaction in flight
// Define MEM_ARB_STARVE_GUARD_EN to let a waiting IF request break a run of STARVE_MAX DM grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic                owner_dm, we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [DATA_W/8-1:0] be_q;
  logic [3:0]          lat_cnt;
  logic                idle, issue, resp, gnt_if, gnt_dm, force_if, capture;
  if (MEM_LAT < 1 || MEM_LAT > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
    $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must be in 1..15");
  end
  // grants are masked while reset is low so every output reads 0 during reset
  assign idle    = state == IDLE && reset;
  assign issue   = state == ISSUE;
  assign resp    = state == RESP;
  assign capture = state == WAIT && lat_cnt == 4'(MEM_LAT);
`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;
  assign force_if = bus.if_req && starve_cnt == 4'(STARVE_MAX);
  always_ff @(posedge clk) begin
    if (!reset) starve_cnt <= '0;
    else if (state == IDLE) starve_cnt <= (gnt_if || !bus.if_req) ? '0 : gnt_dm ? starve_cnt + 4'd1 : starve_cnt;
  end
`else
  assign force_if = 1'b0;
`endif
  assign gnt_dm = idle && bus.dm_req && !force_if;
  assign gnt_if = idle && bus.if_req && !gnt_dm;
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == IDLE  ? ((gnt_if || gnt_dm) ? ISSUE : IDLE) :
               state == ISSUE ? WAIT :
               state == WAIT  ? (capture ? RESP : WAIT) : IDLE;
  end
  // reads carry all-ones byte enables so the issue stage can drive be_q directly
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_dm <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      lat_cnt  <= '0;
      rdata_q  <= '0;
    end else begin
      if (gnt_dm || gnt_if) begin
        owner_dm <= gnt_dm;
        we_q     <= gnt_dm && bus.dm_we;
        addr_q   <= gnt_dm ? bus.dm_addr : bus.if_addr;
        wdata_q  <= gnt_dm ? bus.dm_wdata : '0;
        be_q     <= (gnt_dm && bus.dm_we) ? bus.dm_be : '1;
      end
      lat_cnt <= issue ? 4'd1 : state == WAIT ? lat_cnt + 4'd1 : '0;
      if (capture) rdata_q <= we_q ? '0 : bus.mem_rdata;
    end
  end
  always_comb begin
    bus.if_gnt    = gnt_if;
    bus.dm_gnt    = gnt_dm;
    bus.mem_en    = issue;
    bus.mem_we    = issue && we_q;
    bus.mem_addr  = issue ? addr_q : '0;
    bus.mem_wdata = issue ? wdata_q : '0;
    bus.mem_be    = issue ? be_q : '0;
    bus.if_rvalid = resp && !owner_dm;
    bus.dm_rvalid = resp && owner_dm;
    bus.if_rdata  = (resp && !owner_dm) ? rdata_q : '0;
    bus.dm_rdata  = (resp && owner_dm) ? rdata_q : '0;
    bus.busy      = state != IDLE;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter with a fixed-latency memory model
module tb_mem_port_arbiter;
  localparam int MEM_LAT = 2;
  localparam int STARVE_MAX = 4;
  logic clk = 1'b0;
  logic reset;
  int n_checks = 0, n_errors = 0;
  int n_mem_en = 0, n_if_gnt = 0, n_dm_gnt = 0, n_if_rv = 0;
  int e0, g0, i0, r0, dmb;
  bit seen;
  logic [31:0] mem [0:255];
  logic [31:0] pend_addr;
  int pend;
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  // memory: read data is valid only in the cycle MEM_LAT after mem_en, garbage otherwise
  always @(posedge clk) begin
    if (!reset) mem[16] <= 32'h0050_0093;
    if (bus.mem_en && !bus.mem_we) begin
      pend <= 1;
      pend_addr <= bus.mem_addr;
    end else pend <= (pend != 0 && pend < MEM_LAT) ? pend + 1 : 0;
    if (bus.mem_en && bus.mem_we)
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) mem[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
  end
  assign bus.mem_rdata = (pend == MEM_LAT) ? mem[pend_addr[9:2]] : 32'hBAD0_BAD0;
  always @(negedge clk) begin
    n_mem_en += int'(bus.mem_en);
    n_if_gnt += int'(bus.if_gnt);
    n_dm_gnt += int'(bus.dm_gnt);
    n_if_rv  += int'(bus.if_rvalid);
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic nx();
    @(posedge clk);
    #1;
  endtask
  initial begin
    pend = 0;
    pend_addr = 0;
    reset = 1'b0;
    bus.if_req = 0; bus.if_addr = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = 0; bus.dm_wdata = 0; bus.dm_be = 0;
    repeat (3) nx();
    // requests during reset must not be granted
    bus.if_req = 1; bus.dm_req = 1;
    @(negedge clk);
    chk("rst_flags", {bus.if_gnt, bus.dm_gnt, bus.if_rvalid, bus.dm_rvalid, bus.mem_en, bus.mem_we, bus.busy, bus.mem_be}, 0);
    chk("rst_data", {bus.if_rdata, bus.dm_rdata}, 0);
    chk("rst_mem", {bus.mem_addr, bus.mem_wdata}, 0);
    bus.if_req = 0; bus.dm_req = 0;
    nx();
    reset = 1'b1;
    nx();
    // test 1: IF read 0x40
    bus.if_req = 1; bus.if_addr = 32'h40;
    @(negedge clk);
    chk("t1_if_gnt", bus.if_gnt, 1);
    chk("t1_dm_gnt", bus.dm_gnt, 0);
    nx();
    bus.if_req = 0; bus.if_addr = 0;
    @(negedge clk);
    chk("t1_mem_en", bus.mem_en, 1);
    chk("t1_mem_addr", bus.mem_addr, 32'h40);
    chk("t1_mem_we_be", {bus.mem_we, bus.mem_be}, 5'h0F);
    chk("t1_busy", bus.busy, 1);
    repeat (MEM_LAT) begin
      nx();
      @(negedge clk);
      chk("t1_wait_quiet", {bus.if_rvalid, bus.dm_rvalid, bus.mem_en, bus.if_gnt}, 0);
    end
    nx();
    @(negedge clk);
    chk("t1_if_rvalid", bus.if_rvalid, 1);
    chk("t1_if_rdata", bus.if_rdata, 32'h0050_0093);
    chk("t1_dm_quiet", {bus.dm_rvalid, bus.dm_rdata}, 0);
    nx();
    @(negedge clk);
    chk("t1_idle", {bus.busy, bus.if_rvalid}, 0);
    nx();
    // test 3: DM write 0x100
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEAD_BEEF; bus.dm_be = 4'hF;
    @(negedge clk);
    chk("t3_dm_gnt", {bus.dm_gnt, bus.if_gnt}, 2'b10);
    nx();
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_wdata = 0; bus.dm_be = 0;
    @(negedge clk);
    chk("t3_mem_wr", {bus.mem_en, bus.mem_we, bus.mem_be}, 6'h3F);
    chk("t3_mem_addr_data", {bus.mem_addr, bus.mem_wdata}, {32'h100, 32'hDEAD_BEEF});
    repeat (MEM_LAT + 1) nx();
    @(negedge clk);
    chk("t3_dm_ack", {bus.dm_rvalid, bus.dm_rdata}, {1'b1, 32'h0});
    chk("t3_if_quiet", {bus.if_rvalid, bus.if_rdata}, 0);
    nx();
    nx();
    // partial write: byte enables pass straight through
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h104; bus.dm_wdata = 32'h1122_3344; bus.dm_be = 4'b0101;
    nx();
    bus.dm_req = 0; bus.dm_we = 0;
    @(negedge clk);
    chk("t3_partial_be", {bus.mem_en, bus.mem_we, bus.mem_be}, 6'b11_0101);
    repeat (MEM_LAT + 3) nx();
    // test 2: simultaneous IF and DM read, DM first
    e0 = n_mem_en;
    bus.if_req = 1; bus.if_addr = 32'h40;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h100;
    @(negedge clk);
    chk("t2_gnt_order", {bus.dm_gnt, bus.if_gnt}, 2'b10);
    nx();
    bus.dm_req = 0;
    @(negedge clk);
    chk("t2_dm_issue", {bus.mem_en, bus.mem_addr}, {1'b1, 32'h100});
    repeat (MEM_LAT) begin
      nx();
      @(negedge clk);
      chk("t2_if_held_off", bus.if_gnt, 0);
    end
    nx();
    @(negedge clk);
    chk("t2_dm_rdata", {bus.dm_rvalid, bus.dm_rdata}, {1'b1, 32'hDEAD_BEEF});
    chk("t2_no_if_gnt_in_resp", {bus.if_gnt, bus.if_rvalid}, 0);
    nx();
    @(negedge clk);
    chk("t2_if_gnt_after", bus.if_gnt, 1);
    nx();
    bus.if_req = 0;
    @(negedge clk);
    chk("t2_if_issue", {bus.mem_en, bus.mem_addr}, {1'b1, 32'h40});
    repeat (MEM_LAT + 1) nx();
    @(negedge clk);
    chk("t2_if_rdata", {bus.if_rvalid, bus.if_rdata}, {1'b1, 32'h0050_0093});
    nx();
    chk("t2_mem_en_count", n_mem_en - e0, 2);
    // test 6: IF pulse while busy is forgotten
    e0 = n_mem_en;
    i0 = n_if_gnt;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h100;
    nx();
    bus.dm_req = 0;
    nx();
    bus.if_req = 1; bus.if_addr = 32'h80;
    nx();
    bus.if_req = 0;
    nx();
    @(negedge clk);
    chk("t6_dm_rvalid", bus.dm_rvalid, 1);
    nx();
    @(negedge clk);
    chk("t6_idle_no_gnt", {bus.busy, bus.if_gnt}, 0);
    repeat (3) nx();
    chk("t6_mem_en_count", n_mem_en - e0, 1);
    chk("t6_if_gnt_count", n_if_gnt - i0, 0);
    // test 5: reset during WAIT drops the transaction
    r0 = n_if_rv;
    bus.if_req = 1; bus.if_addr = 32'h40;
    nx();
    bus.if_req = 0;
    nx();
    reset = 1'b0;
    nx();
    reset = 1'b1;
    @(negedge clk);
    chk("t5_after_reset", {bus.busy, bus.mem_en, bus.if_rvalid, bus.dm_rvalid}, 0);
    nx();
    @(negedge clk);
    chk("t5_no_rvalid", bus.if_rvalid, 0);
    repeat (3) nx();
    chk("t5_rvalid_count", n_if_rv - r0, 0);
    bus.if_req = 1; bus.if_addr = 32'h40;
    @(negedge clk);
    chk("t5_regrant", bus.if_gnt, 1);
    nx();
    bus.if_req = 0;
    repeat (MEM_LAT + 1) nx();
    @(negedge clk);
    chk("t5_read_ok", {bus.if_rvalid, bus.if_rdata}, {1'b1, 32'h0050_0093});
    repeat (2) nx();
    // test 4: DM held continuously with IF waiting
    g0 = n_dm_gnt;
    i0 = n_if_gnt;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h100;
    bus.if_req = 1; bus.if_addr = 32'h40;
`ifdef MEM_ARB_STARVE_GUARD_EN
    seen = 0;
    dmb = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (bus.if_gnt) seen = 1;
      else if (bus.dm_gnt) dmb++;
      nx();
    end
    bus.dm_req = 0; bus.if_req = 0;
    chk("t4_if_gnt_seen", seen, 1);
    chk("t4_dm_before_if", dmb, STARVE_MAX);
`else
    repeat (20 * (3 + MEM_LAT)) nx();
    bus.dm_req = 0; bus.if_req = 0;
    nx();
    chk("t4_no_if_gnt", n_if_gnt - i0, 0);
    chk("t4_dm_gnt_count", n_dm_gnt - g0, 20);
`endif
    repeat (MEM_LAT + 4) nx();
    @(negedge clk);
    chk("t4_final_idle", bus.busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
